aer_tx_seq: RTL and testbench
=============================

// Module: aer_tx_seq
// PURPOSE
//  Programmable AER event source driving the ODIN AERIN 4-phase req/ack input.
//  - Replaces the free-running fixed-sweep transmitter with a START-triggered burst generator.
//  - Configurable neuron range, sweep/fixed mode, event code, inter-event gap, event count and abort.
//  - Sits between the test controller (config/status) and the ODIN AERIN port.
// PARAMETERS
//  NEUR_W  8   neuron index width; AERIN_ADDR width is NEUR_W+9
//  GAP_W   16  width of inter-event gap counter
//  CNT_W   16  width of event count / event counter
// PORTS
//  CLK        in   1        clock
//  RST        in   1        reset
//  START      in   1        1-cycle pulse: latch config, begin burst (ignored when BUSY=1)
//  ABORT      in   1        level/pulse: stop burst at next handshake boundary
//  MODE       in   1        0 = sweep FIRST..LAST with wrap, 1 = fixed neuron FIRST
//  FIRST_NEUR in   NEUR_W   first neuron index
//  LAST_NEUR  in   NEUR_W   last neuron index before wrap (sweep mode only)
//  EVT_CODE   in   8        low address byte (e.g. 8'h07)
//  GAP_CYC    in   GAP_W    idle cycles between ACK-low and next REQ rise
//  N_EVENTS   in   CNT_W    events in burst; 0 = run until ABORT
//  AERIN_ACK  in   1        ODIN acknowledge
//  AERIN_REQ  out  1        request, registered
//  AERIN_ADDR out  NEUR_W+9 {1'b0, neuron, evt_code}, registered/held
//  BUSY       out  1        high from cycle after START until burst ends
//  DONE       out  1        1-cycle pulse at burst end
//  EVT_CNT    out  CNT_W    completed handshakes since last START (wraps)
// BEHAVIOUR
//  - Reset: RST synchronous, active-high; clock CLK. All outputs 0; state IDLE; abort flag clear.
//  - Config (MODE, FIRST, LAST, EVT_CODE, GAP, N_EVENTS) latched on accepted START; later input changes are ignored until next START.
//  - States: IDLE, REQ, ACK_LO, GAP.
//  - IDLE + START at cycle t:
//    - N_EVENTS != 0: BUSY=1, AERIN_REQ=1 at t+1, EVT_CNT cleared, neuron=FIRST_NEUR; -> REQ.
//    - N_EVENTS == 0 and ABORT=1 at t: no burst; DONE pulse at t+1.
//  - REQ: hold REQ=1 and ADDR. On ACK=1: REQ<=0, EVT_CNT++, remaining-- (unless infinite); -> ACK_LO.
//  - ACK_LO: wait ACK=0, then one of:
//    - last event or abort flag set: -> IDLE; BUSY<=0, DONE<=1 for one cycle.
//    - else advance neuron; GAP_CYC==0 -> REQ (REQ=1 next cycle); else load gap counter -> GAP.
//  - GAP: REQ=0 for exactly GAP_CYC cycles, then -> REQ. Abort flag seen here -> IDLE with DONE.
//  - Neuron advance:
//    - MODE=1: no change.
//    - MODE=0: ==LAST -> FIRST, else +1 mod 2^NEUR_W.
//    - FIRST>LAST is legal and passes through wrap 2^NEUR_W-1 -> 0.
//  - ADDR changes only while REQ=0 and ACK=0 (4-phase data-valid rule).
//  - ABORT sets the sticky abort flag while BUSY.
//    - REQ is never withdrawn before ACK; the current handshake always completes.
//    - Flag cleared on entering IDLE.
//  - START while BUSY: ignored. ACK high in IDLE/GAP: ignored (no count).
//  - RST mid-handshake: REQ drops next cycle regardless of ACK; state IDLE.
// CONFIGURATION
//  AER_ACK_SYNC_EN defined:
//    - AERIN_ACK passes through a 2-flop synchronizer (reset 0) before FSM use.
//    - Adds 2 cycles to each ACK edge response.
//  AER_ACK_SYNC_EN undefined:
//    - ACK sampled directly; REQ falls 1 cycle after ACK rise.
// TESTING (responses below are for the undefined build; +2 cycles per ACK edge when AER_ACK_SYNC_EN)
//  - Sweep: MODE=0,FIRST=3,LAST=5,EVT_CODE=07,GAP=0,N=5 -> ADDR neurons 3,4,5,3,4; EVT_CNT=5; DONE once; BUSY low.
//  - Fixed+gap: MODE=1,FIRST=9,GAP=4,N=3 -> 3 events at neuron 9; exactly 4 REQ-low cycles after each ACK fall.
//  - Wrap: FIRST=254,LAST=1,N=5 -> neurons 254,255,0,1,254.
//  - Abort: N=0 (infinite), ABORT during REQ of 3rd event -> 3rd handshake completes, EVT_CNT=3, DONE, no 4th REQ.
//  - START while BUSY and N=0 START with ABORT -> first ignored (no config change); second gives DONE at t+1, no REQ.
//  - RST while REQ=1 and ACK=0 -> REQ=0, BUSY=0, EVT_CNT=0 next cycle; later ACK pulse causes no count.

Source files
------------

// File: rtl/aer_tx_seq.sv
// aer_tx_seq: START-triggered AER burst generator driving the ODIN AERIN 4-phase req/ack port.
//
// Emits a burst of address events, either sweeping FIRST_NEUR..LAST_NEUR with wrap or
// repeating FIRST_NEUR, with a programmable idle gap between handshakes. The burst ends
// after N_EVENTS handshakes (0 = until ABORT), always at a handshake boundary.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   START        1-cycle pulse; latches config and begins a burst (ignored while BUSY)
//   ABORT        stop the burst at the next handshake boundary (sticky while BUSY)
//   MODE         0 = sweep FIRST..LAST with wrap, 1 = fixed neuron FIRST
//   FIRST_NEUR   first neuron index
//   LAST_NEUR    last neuron before wrap (sweep mode)
//   EVT_CODE     low address byte
//   GAP_CYC      idle cycles between ACK-low and next REQ rise
//   N_EVENTS     events per burst; 0 = run until ABORT
//   AERIN_ACK    ODIN acknowledge
//   AERIN_REQ    registered request
//   AERIN_ADDR   {1'b0, neuron, evt_code}, held for the whole handshake
//   BUSY         high while a burst is in progress
//   DONE         1-cycle pulse at burst end
//   EVT_CNT      completed handshakes since last START (wraps)
//
// Build option: define AER_ACK_SYNC_EN to pass AERIN_ACK through a 2-flop synchronizer
// (adds 2 cycles to every ACK edge response).

module aer_tx_seq #(
    parameter int unsigned NEUR_W = 8,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              MODE,
    input  logic [NEUR_W-1:0] FIRST_NEUR,
    input  logic [NEUR_W-1:0] LAST_NEUR,
    input  logic [7:0]        EVT_CODE,
    input  logic [GAP_W-1:0]  GAP_CYC,
    input  logic [CNT_W-1:0]  N_EVENTS,
    input  logic              AERIN_ACK,
    output logic              AERIN_REQ,
    output logic [NEUR_W+8:0] AERIN_ADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  EVT_CNT
);

    typedef enum logic [1:0] {StIdle, StReq, StAckLo, StGap} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [NEUR_W-1:0] first_q, first_d;
    logic [NEUR_W-1:0] last_q, last_d;
    logic [7:0]        code_q, code_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              infinite_q, infinite_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [NEUR_W-1:0] neur_q, neur_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic              abort_q, abort_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ack;
    logic              abort_eff;
    logic [NEUR_W-1:0] next_neur;

`ifdef AER_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) ack_sync_q <= '0;
        else     ack_sync_q <= {ack_sync_q[0], AERIN_ACK};
    end

    assign ack = ack_sync_q[1];
`else
    assign ack = AERIN_ACK;
`endif

    // A same-cycle ABORT counts as well as the sticky flag, so the boundary decision
    // does not lag the request by a cycle.
    assign abort_eff = abort_q | ABORT;

    // Sweep wraps LAST -> FIRST; plain +1 rolls over 2^NEUR_W-1 -> 0 when FIRST > LAST.
    assign next_neur = mode_q ? neur_q :
                       (neur_q == last_q) ? first_q : neur_q + 1'b1;

    // State and datapath register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
            code_q     <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            infinite_q <= 1'b0;
            remain_q   <= '0;
            neur_q     <= '0;
            evt_cnt_q  <= '0;
            abort_q    <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            first_q    <= first_d;
            last_q     <= last_d;
            code_q     <= code_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            infinite_q <= infinite_d;
            remain_q   <= remain_d;
            neur_q     <= neur_d;
            evt_cnt_q  <= evt_cnt_d;
            abort_q    <= abort_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        first_d    = first_q;
        last_d     = last_q;
        code_d     = code_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        infinite_d = infinite_q;
        remain_d   = remain_q;
        neur_d     = neur_q;
        evt_cnt_d  = evt_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (START) begin
                    mode_d     = MODE;
                    first_d    = FIRST_NEUR;
                    last_d     = LAST_NEUR;
                    code_d     = EVT_CODE;
                    gap_d      = GAP_CYC;
                    remain_d   = N_EVENTS;
                    infinite_d = (N_EVENTS == '0);
                    evt_cnt_d  = '0;
                    if ((N_EVENTS == '0) && ABORT) begin
                        done_d = 1'b1;
                    end else begin
                        neur_d  = FIRST_NEUR;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (ack) begin
                    evt_cnt_d = evt_cnt_q + 1'b1;
                    if (!infinite_q) remain_d = remain_q - 1'b1;
                    state_d = StAckLo;
                end
            end
            StAckLo: begin
                if (!ack) begin
                    if ((!infinite_q && (remain_q == '0)) || abort_eff) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        // REQ and ACK are both low here, so the address may change.
                        neur_d = next_neur;
                        if (gap_q == '0) begin
                            state_d = StReq;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (abort_eff) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = StReq;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: registered outputs follow the next state
    always_comb begin
        req_d   = (state_d == StReq);
        busy_d  = (state_d != StIdle);
        abort_d = (state_d == StIdle) ? 1'b0 : (abort_q | (busy_q & ABORT));
    end

    assign AERIN_REQ  = req_q;
    assign AERIN_ADDR = {1'b0, neur_q, code_q};
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign EVT_CNT    = evt_cnt_q;

endmodule

// File: tb/tb_aer_tx_seq.sv
// Directed bench for aer_tx_seq: sweep, fixed+gap, wrap, abort, START-while-busy, reset.

module tb_aer_tx_seq;

`ifdef AER_ACK_SYNC_EN
    localparam int AckLat = 3;
`else
    localparam int AckLat = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        MODE = 1'b0;
    logic [7:0]  FIRST_NEUR = '0;
    logic [7:0]  LAST_NEUR = '0;
    logic [7:0]  EVT_CODE = '0;
    logic [15:0] GAP_CYC = '0;
    logic [15:0] N_EVENTS = '0;
    logic        AERIN_ACK = 1'b0;
    logic        AERIN_REQ;
    logic [16:0] AERIN_ADDR;
    logic        BUSY;
    logic        DONE;
    logic [15:0] EVT_CNT;

    int checks = 0;
    int errors = 0;
    logic [7:0] cur_code;

    aer_tx_seq #(.NEUR_W(8), .GAP_W(16), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .MODE       (MODE),
        .FIRST_NEUR (FIRST_NEUR),
        .LAST_NEUR  (LAST_NEUR),
        .EVT_CODE   (EVT_CODE),
        .GAP_CYC    (GAP_CYC),
        .N_EVENTS   (N_EVENTS),
        .AERIN_ACK  (AERIN_ACK),
        .AERIN_REQ  (AERIN_REQ),
        .AERIN_ADDR (AERIN_ADDR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .EVT_CNT    (EVT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse START with the given config, then scramble the inputs to prove they were latched.
    task automatic start_burst(input logic mode, input logic [7:0] first, input logic [7:0] last,
                               input logic [7:0] code, input logic [15:0] gap,
                               input logic [15:0] n);
        MODE = mode; FIRST_NEUR = first; LAST_NEUR = last; EVT_CODE = code;
        GAP_CYC = gap; N_EVENTS = n; cur_code = code;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("start_busy", BUSY, 1);
        chk("start_req", AERIN_REQ, 1);
        chk("start_cnt", EVT_CNT, 0);
        MODE = ~mode; FIRST_NEUR = ~first; LAST_NEUR = ~last; EVT_CODE = ~code;
        GAP_CYC = gap + 16'd7; N_EVENTS = n + 16'd9;
    endtask

    // One full handshake; checks address, REQ-fall latency, and either the gap or burst end.
    task automatic hs(input logic [7:0] neur, input bit last, input int gap, input int cnt,
                      input bit do_abort);
        int n;
        n = 0;
        while (!AERIN_REQ && n < 100) begin tick(); n++; end
        chk("req_high", AERIN_REQ, 1);
        chk("addr", AERIN_ADDR, {15'd0, 1'b0, neur, cur_code});
        if (do_abort) begin
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            chk("req_held_abort", AERIN_REQ, 1);
        end
        AERIN_ACK = 1'b1;
        n = 0;
        do begin tick(); n++; end while (AERIN_REQ && n < 100);
        chk("req_fall_lat", n, AckLat);
        chk("evt_cnt", EVT_CNT, cnt);
        AERIN_ACK = 1'b0;
        n = 0;
        if (last) begin
            do begin tick(); n++; end while (BUSY && n < 100);
            chk("done_lat", n, AckLat);
            chk("done_pulse", DONE, 1);
            chk("end_req", AERIN_REQ, 0);
            tick();
            chk("done_clear", DONE, 0);
        end else begin
            do begin tick(); n++; end while (!AERIN_REQ && n < 100);
            chk("gap", n - AckLat, gap);
        end
    endtask

    initial begin
        cur_code = 8'h00;
        repeat (3) tick();
        chk("rst_req", AERIN_REQ, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_cnt", EVT_CNT, 0);
        chk("rst_addr", AERIN_ADDR, 0);
        RST = 1'b0;
        tick();

        // Sweep 3..5, no gap
        start_burst(1'b0, 8'd3, 8'd5, 8'h07, 16'd0, 16'd5);
        hs(8'd3, 0, 0, 1, 0);
        hs(8'd4, 0, 0, 2, 0);
        hs(8'd5, 0, 0, 3, 0);
        hs(8'd3, 0, 0, 4, 0);
        hs(8'd4, 1, 0, 5, 0);
        chk("sweep_busy", BUSY, 0);
        chk("sweep_cnt", EVT_CNT, 5);
        repeat (3) tick();

        // Fixed neuron with a 4-cycle gap
        start_burst(1'b1, 8'd9, 8'd0, 8'h07, 16'd4, 16'd3);
        hs(8'd9, 0, 4, 1, 0);
        hs(8'd9, 0, 4, 2, 0);
        hs(8'd9, 1, 0, 3, 0);
        repeat (3) tick();

        // FIRST > LAST wraps through 255 -> 0
        start_burst(1'b0, 8'd254, 8'd1, 8'h5a, 16'd1, 16'd5);
        hs(8'd254, 0, 1, 1, 0);
        hs(8'd255, 0, 1, 2, 0);
        hs(8'd0,   0, 1, 3, 0);
        hs(8'd1,   0, 1, 4, 0);
        hs(8'd254, 1, 0, 5, 0);
        repeat (3) tick();

        // Infinite burst, ABORT during REQ of the third event
        start_burst(1'b0, 8'd10, 8'd20, 8'h07, 16'd0, 16'd0);
        hs(8'd10, 0, 0, 1, 0);
        hs(8'd11, 0, 0, 2, 0);
        hs(8'd12, 1, 0, 3, 1);
        repeat (5) tick();
        chk("abort_no_req", AERIN_REQ, 0);
        chk("abort_cnt", EVT_CNT, 3);
        chk("abort_busy", BUSY, 0);

        // START while busy is ignored
        start_burst(1'b1, 8'd40, 8'd0, 8'h11, 16'd0, 16'd2);
        MODE = 1'b0; FIRST_NEUR = 8'd50; N_EVENTS = 16'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        hs(8'd40, 0, 0, 1, 0);
        hs(8'd40, 1, 0, 2, 0);
        tick();

        // N=0 START together with ABORT: DONE next cycle, no burst
        N_EVENTS = 16'd0;
        ABORT = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        chk("nb_done", DONE, 1);
        chk("nb_busy", BUSY, 0);
        chk("nb_req", AERIN_REQ, 0);
        chk("nb_cnt", EVT_CNT, 0);
        tick();
        chk("nb_done_clear", DONE, 0);
        chk("nb_req2", AERIN_REQ, 0);

        // Reset in the middle of a handshake
        start_burst(1'b1, 8'd5, 8'd0, 8'h07, 16'd0, 16'd3);
        hs(8'd5, 0, 0, 1, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_req", AERIN_REQ, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_cnt", EVT_CNT, 0);
        AERIN_ACK = 1'b1;
        repeat (4) tick();
        AERIN_ACK = 1'b0;
        repeat (4) tick();
        chk("post_rst_cnt", EVT_CNT, 0);
        chk("post_rst_req", AERIN_REQ, 0);
        chk("post_rst_busy", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
